// File: rtl/enc_queue_rr.sv
// enc_queue_rr: N-input event encoder with a pending-request register and a
// one-entry registered output slot behind a valid/ready handshake.
// Pending requests drain one per accepted cycle, picked either by fixed
// priority (lowest index first) or round-robin starting from a pointer.
module enc_queue_rr #(
  parameter int N    = 8,
  parameter int MODE = 0,
  parameter int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] i,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pend,
  output logic         ovf
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         ovf_q, ovf_d;

  logic         slot_free;
  logic         grant;
  logic [W-1:0] sel;
  logic         found;
  logic [N-1:0] grant_mask;
  int           scan_pos;

  // Pick the winning pending line: scan upward from 0 (fixed) or from ptr
  // (round-robin), wrapping past N-1 so non-power-of-two N never yields >= N.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_pos = 0;
    for (int k = 0; k < N; k++) begin
      scan_pos = (MODE == 1) ? int'(ptr_q) + k : k;
      if (scan_pos >= N) begin
        scan_pos = scan_pos - N;
      end
      if (!found && pend_q[scan_pos]) begin
        found = 1'b1;
        sel   = W'(scan_pos);
      end
    end
  end

  // Compute the slot handshake, the grant, and every next-state value.
  always_comb begin
    slot_free  = !valid_q || ready;
    grant      = slot_free && found;
    grant_mask = grant ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

    pend_d  = pend_q & ~grant_mask;
    y_d     = y_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    ovf_d   = 1'b0;

    if (en) begin
      pend_d = pend_d | i;
      ovf_d  = |(i & pend_q & ~grant_mask);
    end

    if (grant) begin
      y_d     = sel;
      valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = (sel == W'(N - 1)) ? '0 : sel + W'(1);
      end
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset flushes pending and in-slot requests at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_enc_queue_rr.sv
// tb_enc_queue_rr: drives three encoder configurations (N=8 fixed, N=8
// round-robin, N=5 round-robin) with shared directed and random stimulus.
// A behavioural model predicts every grant into per-instance queues, and a
// negedge monitor pops them whenever an instance hands over an index.
module tb_enc_queue_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] i_in;
  logic       ready;

  logic [2:0] y0, y1, y2;
  logic       valid0, valid1, valid2;
  logic [7:0] pend0, pend1;
  logic [4:0] pend2;
  logic       ovf0, ovf1, ovf2;

  logic [2:0] y_w     [3];
  logic       valid_w [3];
  logic [7:0] pend_w  [3];
  logic       ovf_w   [3];

  int tests_run = 0;
  int failures  = 0;

  // Behavioural model state per instance.
  int         n_of    [3] = '{8, 8, 5};
  int         mode_of [3] = '{0, 1, 1};
  logic [7:0] pend_m  [3];
  int         y_m     [3];
  bit         valid_m [3];
  int         ptr_m   [3];
  bit         ovf_m   [3];
  int         exp_q   [3][$];

  always #5 clk = ~clk;

  enc_queue_rr #(.N(8), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i_in), .y(y0), .valid(valid0),
    .ready(ready), .pend(pend0), .ovf(ovf0)
  );

  enc_queue_rr #(.N(8), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i_in), .y(y1), .valid(valid1),
    .ready(ready), .pend(pend1), .ovf(ovf1)
  );

  enc_queue_rr #(.N(5), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i_in[4:0]), .y(y2), .valid(valid2),
    .ready(ready), .pend(pend2), .ovf(ovf2)
  );

  assign y_w[0] = y0;
  assign y_w[1] = y1;
  assign y_w[2] = y2;
  assign valid_w[0] = valid0;
  assign valid_w[1] = valid1;
  assign valid_w[2] = valid2;
  assign pend_w[0] = pend0;
  assign pend_w[1] = pend1;
  assign pend_w[2] = {3'b000, pend2};
  assign ovf_w[0] = ovf0;
  assign ovf_w[1] = ovf1;
  assign ovf_w[2] = ovf2;

  // Single comparison point: counts the test and reports a mismatch.
  task automatic check(input string name, input int d, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, actual, expected, $time);
    end
  endtask

  // Choose the next line to serve from the model's pending set.
  function automatic int pick(input int d);
    int idx;
    for (int k = 0; k < n_of[d]; k++) begin
      idx = (mode_of[d] == 1) ? (ptr_m[d] + k) % n_of[d] : k;
      if (pend_m[d][idx]) return idx;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input int d, input bit e, input logic [7:0] iv, input bit r);
    logic [7:0] mask;
    logic [7:0] gm;
    logic [7:0] iv_m;
    int         g;
    mask = (n_of[d] == 8) ? 8'hFF : 8'h1F;
    iv_m = iv & mask;
    gm   = 8'h00;
    if (!valid_m[d] || r) begin
      g = pick(d);
      if (g >= 0) begin
        gm         = 8'h01 << g;
        y_m[d]     = g;
        valid_m[d] = 1'b1;
        exp_q[d].push_back(g);
        if (mode_of[d] == 1) ptr_m[d] = (g + 1) % n_of[d];
      end else begin
        valid_m[d] = 1'b0;
      end
    end
    ovf_m[d]  = e && ((iv_m & pend_m[d] & ~gm) != 8'h00);
    pend_m[d] = (pend_m[d] & ~gm) | (e ? iv_m : 8'h00);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      pend_m[d]  = 8'h00;
      y_m[d]     = 0;
      valid_m[d] = 1'b0;
      ptr_m[d]   = 0;
      ovf_m[d]   = 1'b0;
      exp_q[d].delete();
    end
  endtask

  // Compare per-cycle state of every instance against the model.
  task automatic check_output();
    for (int d = 0; d < 3; d++) begin
      check("pend", d, int'(pend_w[d]), int'(pend_m[d]));
      check("valid", d, int'(valid_w[d]), int'(valid_m[d]));
      check("ovf", d, int'(ovf_w[d]), int'(ovf_m[d]));
      if (valid_m[d]) check("y_held", d, int'(y_w[d]), y_m[d]);
    end
  endtask

  // One clock of stimulus: drive, predict, let the edge happen, then check.
  task automatic apply_stimulus(input bit e, input logic [7:0] iv, input bit r);
    en    = e;
    i_in  = iv;
    ready = r;
    for (int d = 0; d < 3; d++) model_step(d, e, iv, r);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic check_reset_values();
    for (int d = 0; d < 3; d++) begin
      check("rst_y", d, int'(y_w[d]), 0);
      check("rst_valid", d, int'(valid_w[d]), 0);
      check("rst_pend", d, int'(pend_w[d]), 0);
      check("rst_ovf", d, int'(ovf_w[d]), 0);
    end
  endtask

  // Scoreboard monitor: an index is handed over whenever valid && ready.
  always @(negedge clk) begin
    int got;
    int want;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (valid_w[d] && ready) begin
          got = int'(y_w[d]);
          check("y_range", d, int'(got < n_of[d]), 1);
          if (exp_q[d].size() == 0) begin
            check("unexpected_y", d, got, -1);
          end else begin
            want = exp_q[d].pop_front();
            check("y_order", d, got, want);
          end
        end
      end
    end
  end

  // Run-away guard in case the stimulus process ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rnd;
    model_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    i_in  = 8'h00;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();

    // Single pulse on line 3: valid with y=3 two edges later, then empty.
    apply_stimulus(1'b1, 8'h08, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("lat_valid", 0, int'(valid0), 1);
    check("lat_y", 0, int'(y0), 3);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("lat_drained", 0, int'(valid0), 0);
    check("lat_pend", 0, int'(pend0), 0);

    // Multi-hot burst drains in priority order.
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    repeat (6) apply_stimulus(1'b0, 8'h00, 1'b1);

    // All lines held: round-robin cycles through every index.
    repeat (12) apply_stimulus(1'b1, 8'hFF, 1'b1);
    repeat (10) apply_stimulus(1'b0, 8'h00, 1'b1);

    // Back-pressure: slot holds line 1 while line 6 waits.
    apply_stimulus(1'b1, 8'h42, 1'b0);
    repeat (5) apply_stimulus(1'b0, 8'h00, 1'b0);
    check("bp_y", 0, int'(y0), 1);
    check("bp_pend", 0, int'(pend0), 8'h40);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("bp_next_y", 0, int'(y0), 6);
    repeat (3) apply_stimulus(1'b0, 8'h00, 1'b1);

    // Overflow: re-pulse a pending line while stalled, then with en low.
    apply_stimulus(1'b1, 8'h01, 1'b0);
    apply_stimulus(1'b1, 8'h10, 1'b0);
    apply_stimulus(1'b1, 8'h10, 1'b0);
    check("ovf_pulse", 0, int'(ovf0), 1);
    apply_stimulus(1'b0, 8'h10, 1'b0);
    check("ovf_gated", 0, int'(ovf0), 0);
    check("ovf_pend", 0, int'(pend0), 8'h10);
    repeat (4) apply_stimulus(1'b0, 8'h00, 1'b1);

    // Randomized traffic with random enable and back-pressure.
    for (int c = 0; c < 400; c++) begin
      rnd = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00;
      apply_stimulus($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 2) != 0);
    end

    // Reset mid-stream with a full slot and several lines pending.
    apply_stimulus(1'b0, 8'h00, 1'b1);
    repeat (4) apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 8'h01, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 8'h16, 1'b0);
    check("pre_rst_pend", 2, int'(pend2), 5'b10110);
    en   = 1'b0;
    i_in = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output();

    // After reset, N=5 round-robin serves 0 then 4.
    apply_stimulus(1'b1, 8'h11, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("n5_first", 2, int'(y2), 0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("n5_second", 2, int'(y2), 4);

    // Final drain: every predicted index must have been delivered.
    repeat (20) apply_stimulus(1'b0, 8'h00, 1'b1);
    for (int d = 0; d < 3; d++) check("queue_empty", d, exp_q[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/enc_queue_rr.md
# enc_queue_rr

Parametrised N-to-log2(N) event encoder with request capture, one-entry registered output and a valid/ready handshake. Single-cycle pulses on any of N request lines are latched into a pending register. Pending requests are encoded one at a time, by fixed or round-robin priority, and delivered as binary indices to a downstream consumer. It replaces the plain combinational 8:3 encoder wherever requests can be multi-hot, back-to-back or back-pressured.

## Interface
- N, default 8: number of request lines; must be ≥2. It need not be a power of two.
- MODE, default 0: 0 selects fixed priority, where the lowest index wins. 1 selects round-robin.
- W, default $clog2(N): width of the index. Derived; it must not be overridden.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to clk, handled by the integrator.
- en  input  1  capture enable. When 0, `i` is ignored.
- i  input  N  request lines, sampled each clk edge when en=1.
- y  output  W  encoded index of the presented request.
- valid  output  1  y holds a request.
- ready  input  1  the consumer accepts y when valid && ready.
- pend  output  N  current pending register, for debug and status.
- ovf  output  1  one-cycle pulse: a request arrived on a line that was already pending and not being granted. The second request is coalesced and lost.

## Operation
- Capture: at each edge with en=1, pend_next = (pend & ~grant_mask) | i.
  - A bit in `i` that coincides with the bit being granted in that same cycle re-pends. Set wins; it counts as a new event.
- Output slot is free when valid=0, or when valid && ready.
  - When the slot is free and (pend & ~grant_mask) is nonzero before this cycle's capture, the selected index loads into y and valid=1.
  - The selected pend bit clears in the same edge (grant_mask).
  - Requests captured in this edge are not eligible until the next cycle.
- Slot free and nothing pending: valid goes to 0. y holds its last value; its value is don't-care while valid=0.
- valid && !ready: y, valid and the RR pointer hold. pend continues to accept captures.
- Selection, MODE=0: lowest set index of pend.
- Selection, MODE=1: first set index scanning upward from ptr, wrapping N-1→0.
  - On each grant, ptr = (granted+1) mod N; N-1 wraps to 0.
  - MODE=0 does not use ptr; ptr stays 0.
- ovf=1 for one cycle when en=1 and (i & pend & ~grant_mask) is nonzero. Otherwise ovf=0.
- en=0 only blocks capture. Draining and the handshake continue.
- Indices ≥N are never produced.

## Timing
- Reset values: y=0, valid=0, pend=0, ovf=0, ptr=0.
- Reset asserted mid-operation discards all pending and in-slot requests immediately.
- Latency: a request sampled at edge t, with an empty slot and no competitors, gives valid=1 and y=index after edge t+1, i.e. 2 cycles.
- Throughput: one index per cycle while ready=1 and pend is nonzero.
- Handshake: valid never deasserts and y never changes while valid && !ready.
- Simultaneous multi-hot input: all bits pend; they drain in priority order, one per accepted cycle.
- All-ones input with N=8 and ready=1: 8 consecutive valid cycles.
- A capture and a grant of the same bit in the same edge: the bit remains set in pend, and the event is not reported as ovf.

## Test plan
- Reset/idle, N=8 MODE=0: after rst_n release, y=0, valid=0, pend=0. Single pulse i=8'b0000_1000 at edge t -> valid=1, y=3 after edge t+1. ready=1 -> valid=0 the next cycle, pend=0.
- Multi-hot fixed priority: i=8'b1010_0101 for one cycle, ready=1 -> y sequence 0,2,5,7 on consecutive cycles, then valid=0.
- Round-robin, MODE=1:
  - i=8'b1111_1111 held with en=1 and ready=1 -> y sequence 0,1,…,7,0,1,…, ptr wrapping 7→0.
  - Lines 7 and 0 are never starved.
- Back-pressure:
  - i=8'b0100_0010 then ready=0 for 5 cycles -> y=1 and valid=1 stable throughout, pend=8'b0100_0000.
  - ready=1 -> y=6 the next cycle.
- Overflow/coalesce: with ready=0 and bit 4 pending, pulse i[4] again -> ovf=1 for exactly one cycle; only one y=4 is delivered. Same pulse with en=0 -> ovf=0 and pend unchanged.
- Reset mid-stream, plus N=5 MODE=1:
  - rst_n low while pend=5'b10110 and valid=1 -> all outputs return to reset values at once.
  - After release, i=5'b10001 -> y=0 then 4. No index above 4 ever appears.
